w_hc595_driver: RTL and testbench
=================================

W_HC595_DRIVER -- requirements
Module: w_hc595_driver

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bits per frame; legal range 2..32.
REQ-002 SHALL have parameter DIV, default 2: CLK cycles per SHCP half-period; legal range 1..255; 0 is illegal.
REQ-003 SHALL have port CLK  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port R  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port DIN  input  WIDTH  parallel frame data, sampled only on the accept edge.
REQ-006 SHALL have port START  input  1  transfer request, level-sensitive, sampled each rising edge.
REQ-007 SHALL have port BUSY  output  1  high in every state except IDLE.
REQ-008 SHALL have port DONE  output  1  one-cycle pulse at frame completion.
REQ-009 SHALL have port SER  output  1  serial data to the 74HC595 DS pin.
REQ-010 SHALL have port SHCP  output  1  shift clock to the 74HC595.
REQ-011 SHALL have port STCP  output  1  storage-register latch to the 74HC595.

Function
REQ-012 SHALL implement the states IDLE, SETUP, CLKH, LATCH and FIN, all with registered outputs.
REQ-013 SHALL accept a request on the rising edge where state is IDLE and START=1: capture DIN into the shift register, clear the bit counter, go to SETUP.
REQ-014 SHALL ignore START in every state other than IDLE, with no queuing and no DIN capture.
REQ-015 SHALL, in SETUP, drive SHCP=0 and SER=current bit for DIV cycles, then go to CLKH.
REQ-016 SHALL, in CLKH, drive SHCP=1 with SER held stable for DIV cycles, then advance the shift register and counter.
REQ-017 SHALL, after CLKH, go to LATCH if the counter has reached WIDTH-1, otherwise go to SETUP.
REQ-018 SHALL, in LATCH, drive STCP=1, SHCP=0 and SER=0 for DIV cycles, then go to FIN.
REQ-019 SHALL, in FIN, drive DONE=1 for exactly one cycle, then go to IDLE unconditionally.
REQ-020 SHALL keep BUSY high for exactly 2*WIDTH*DIV + DIV + 1 cycles per frame.
REQ-021 SHALL, with START held high continuously, leave exactly one IDLE cycle between FIN and the next accept.
REQ-022 SHALL, in IDLE, drive SER=0, SHCP=0, STCP=0 and DONE=0.
REQ-023 SHALL never change SER in the same cycle that SHCP rises, giving DIV cycles of setup before the edge.
REQ-024 SHALL size the divider counter to ceil(log2(DIV+1)) bits and the bit counter to ceil(log2(WIDTH)) bits, with no wrap inside a frame.

Reset
REQ-025 SHALL, while R=1, force state=IDLE, clear the shift register, and drive BUSY, DONE, SER, SHCP and STCP to 0 immediately, independent of CLK.
REQ-026 SHALL, on reset mid-frame, abandon the frame with no STCP pulse and no DONE pulse.
REQ-027 SHALL accept no START on the first rising edge after R deasserts.

Configuration
REQ-028 SHALL, when W_HC595_LSB_FIRST_EN is defined, shift DIN[0] out first and DIN[WIDTH-1] last.
REQ-029 SHALL, when W_HC595_LSB_FIRST_EN is undefined, shift DIN[WIDTH-1] out first (MSB first, the default).

Verification
REQ-030 Reset mid-frame: WIDTH=8, DIV=2, DIN=8'hA5, pulse R during bit 3 -> all outputs 0 immediately, no STCP, no DONE, IDLE after release.
REQ-031 Single MSB-first frame: WIDTH=8, DIV=2, DIN=8'hA5, START pulsed one cycle -> SER at the eight SHCP rises = 1,0,1,0,0,1,0,1; BUSY high for 35 cycles; one STCP pulse 2 cycles wide; one DONE.
REQ-032 Busy-time request: START asserted again during bit 4 with DIN=8'h3C -> frame still carries 8'hA5; no second frame starts.
REQ-033 Back-to-back: START held high, DIN=8'hFF then 8'h00 -> two frames with exactly one IDLE cycle between FIN and the next BUSY rise.
REQ-034 LSB-first build: W_HC595_LSB_FIRST_EN defined, DIN=8'h01 -> SER=1 only at the first SHCP rise.
REQ-035 Minimum-divider build: DIV=1, WIDTH=4, DIN=4'h9 -> SHCP toggles every cycle; BUSY high for 10 cycles; a model 74HC595 latches 4'h9.

Source files
------------

// File: rtl/w_hc595_driver.sv
`default_nettype none
// ============================================================================
// Module   : w_hc595_driver
// Purpose  : Serialises a WIDTH-bit frame into a 74HC595 (DS/SHCP/STCP).
//            Define W_HC595_LSB_FIRST_EN to shift DIN[0] first (default MSB).
// Revision : 1.0 - initial release
// ============================================================================
module w_hc595_driver #(
  parameter int WIDTH = 8,
  parameter int DIV   = 2
) (
  input  logic             CLK,
  input  logic             R,
  input  logic [WIDTH-1:0] DIN,
  input  logic             START,
  output logic             BUSY,
  output logic             DONE,
  output logic             SER,
  output logic             SHCP,
  output logic             STCP
);

  localparam int c_DIV_W = $clog2(DIV + 1);
  localparam int c_BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(DIV - 1);
  localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_CLKH  = 3'd2,
    S_LATCH = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_shreg, w_shreg_nxt, w_shifted;
  logic [c_BIT_W-1:0] r_bitcnt, w_bitcnt_nxt;
  logic [c_DIV_W-1:0] r_divcnt, w_divcnt_nxt;
  logic               r_arm;
  logic               r_busy, r_done, r_ser, r_shcp, r_stcp;
  logic               w_div_last, w_bit_last, w_out_bit;

`ifdef W_HC595_LSB_FIRST_EN
  assign w_shifted = {1'b0, r_shreg[WIDTH-1:1]};
  assign w_out_bit = w_shreg_nxt[0];
`else
  assign w_shifted = {r_shreg[WIDTH-2:0], 1'b0};
  assign w_out_bit = w_shreg_nxt[WIDTH-1];
`endif

  assign w_div_last = (r_divcnt == c_DIV_LAST);
  assign w_bit_last = (r_bitcnt == c_BIT_LAST);

  always_comb begin
    w_state_nxt  = r_state;
    w_shreg_nxt  = r_shreg;
    w_bitcnt_nxt = r_bitcnt;
    w_divcnt_nxt = r_divcnt;
    case (r_state)
      S_IDLE: begin
        // r_arm blocks an accept on the first edge after reset release
        if (START && r_arm) begin
          w_shreg_nxt  = DIN;
          w_bitcnt_nxt = '0;
          w_divcnt_nxt = '0;
          w_state_nxt  = S_SETUP;
        end
      end
      S_SETUP: begin
        if (w_div_last) begin
          w_divcnt_nxt = '0;
          w_state_nxt  = S_CLKH;
        end else begin
          w_divcnt_nxt = r_divcnt + 1'b1;
        end
      end
      S_CLKH: begin
        if (w_div_last) begin
          w_divcnt_nxt = '0;
          w_shreg_nxt  = w_shifted;
          if (w_bit_last) begin
            w_state_nxt = S_LATCH;
          end else begin
            w_bitcnt_nxt = r_bitcnt + 1'b1;
            w_state_nxt  = S_SETUP;
          end
        end else begin
          w_divcnt_nxt = r_divcnt + 1'b1;
        end
      end
      S_LATCH: begin
        if (w_div_last) begin
          w_divcnt_nxt = '0;
          w_state_nxt  = S_FIN;
        end else begin
          w_divcnt_nxt = r_divcnt + 1'b1;
        end
      end
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge R) begin
    if (R) begin
      r_state  <= S_IDLE;
      r_shreg  <= '0;
      r_bitcnt <= '0;
      r_divcnt <= '0;
      r_arm    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ser    <= 1'b0;
      r_shcp   <= 1'b0;
      r_stcp   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_shreg  <= w_shreg_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_divcnt <= w_divcnt_nxt;
      r_arm    <= 1'b1;
      // Outputs are registered from the next state so they align with r_state
      r_busy   <= (w_state_nxt != S_IDLE);
      r_done   <= (w_state_nxt == S_FIN);
      r_ser    <= ((w_state_nxt == S_SETUP) || (w_state_nxt == S_CLKH)) ? w_out_bit : 1'b0;
      r_shcp   <= (w_state_nxt == S_CLKH);
      r_stcp   <= (w_state_nxt == S_LATCH);
    end
  end

  assign BUSY = r_busy;
  assign DONE = r_done;
  assign SER  = r_ser;
  assign SHCP = r_shcp;
  assign STCP = r_stcp;

endmodule
`default_nettype wire

// File: tb/tb_w_hc595_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_w_hc595_driver
// Purpose  : Directed, table-driven bench for w_hc595_driver (8/2 and 4/1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_w_hc595_driver;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic       start;
  logic       sel;

  logic busy_a, done_a, ser_a, shcp_a, stcp_a;
  logic busy_b, done_b, ser_b, shcp_b, stcp_b;
  logic start_a, start_b;
  logic [3:0] din_b;
  logic m_busy, m_done, m_ser, m_shcp, m_stcp;

  assign start_a = start & ~sel;
  assign start_b = start & sel;
  assign din_b   = din[3:0];
  assign m_busy  = sel ? busy_b : busy_a;
  assign m_done  = sel ? done_b : done_a;
  assign m_ser   = sel ? ser_b  : ser_a;
  assign m_shcp  = sel ? shcp_b : shcp_a;
  assign m_stcp  = sel ? stcp_b : stcp_a;

  w_hc595_driver #(.WIDTH(8), .DIV(2)) u_dut_a (
    .CLK(clk), .R(rst), .DIN(din), .START(start_a),
    .BUSY(busy_a), .DONE(done_a), .SER(ser_a), .SHCP(shcp_a), .STCP(stcp_a)
  );

  w_hc595_driver #(.WIDTH(4), .DIV(1)) u_dut_b (
    .CLK(clk), .R(rst), .DIN(din_b), .START(start_b),
    .BUSY(busy_b), .DONE(done_b), .SER(ser_b), .SHCP(shcp_b), .STCP(stcp_b)
  );

  // Behavioural 74HC595 shift/storage registers
  logic [7:0] sr_a = '0, latch_a = '0;
  logic [7:0] sr_b = '0, latch_b = '0;
  always @(posedge shcp_a) sr_a <= {sr_a[6:0], ser_a};
  always @(posedge stcp_a) latch_a <= sr_a;
  always @(posedge shcp_b) sr_b <= {sr_b[6:0], ser_b};
  always @(posedge stcp_b) latch_b <= sr_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  int         o_busy, o_rises, o_shcp_hi, o_stcp, o_done, o_serchg;
  logic [7:0] o_cap;
  logic [3:0] o_idle;
  logic       o_first_busy, o_timeout;

  // Observes one frame at negedges; returns at the first IDLE negedge after BUSY.
  task automatic run_frame(input logic [7:0] d, input logic [7:0] d_after, input bit hold,
                           input int inject, input bit do_start);
    bit   seen = 0, inj = 0;
    int   inj_k = 0;
    logic prev_shcp = 0, prev_ser = 0;
    o_busy = 0; o_rises = 0; o_shcp_hi = 0; o_stcp = 0; o_done = 0; o_serchg = 0;
    o_cap = '0; o_idle = '1; o_first_busy = 0; o_timeout = 1;
    if (do_start) begin
      @(negedge clk);
      din = d; start = 1'b1;
    end
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (k == 0) begin
        din = d_after;
        if (!hold) start = 1'b0;
        o_first_busy = m_busy;
      end
      if (inject > 0 && !inj && o_rises == inject) begin
        start = 1'b1; din = 8'h3C; inj = 1; inj_k = k;
      end else if (inj && k == inj_k + 2) begin
        start = 1'b0;
      end
      if (m_busy) begin seen = 1; o_busy++; end
      if (m_shcp && !prev_shcp) begin
        o_rises++;
        o_cap = {o_cap[6:0], m_ser};
        if (m_ser !== prev_ser) o_serchg++;
      end
      if (m_shcp) o_shcp_hi++;
      if (m_stcp) o_stcp++;
      if (m_done) o_done++;
      prev_shcp = m_shcp;
      prev_ser  = m_ser;
      if (seen && !m_busy) begin
        o_idle = {m_ser, m_shcp, m_stcp, m_done};
        o_timeout = 0;
        break;
      end
    end
  endtask

  typedef struct {
    logic [7:0] din;
    logic [7:0] exp_msb;
    logic [7:0] exp_lsb;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [7:0] exp;
    int rs, stc, dn, extra;
    logic prev;

    vecs[0] = '{din: 8'hA5, exp_msb: 8'hA5, exp_lsb: 8'hA5};
    vecs[1] = '{din: 8'h01, exp_msb: 8'h01, exp_lsb: 8'h80};
    vecs[2] = '{din: 8'hC1, exp_msb: 8'hC1, exp_lsb: 8'h83};
    vecs[3] = '{din: 8'h12, exp_msb: 8'h12, exp_lsb: 8'h48};
    vecs[4] = '{din: 8'hFF, exp_msb: 8'hFF, exp_lsb: 8'hFF};

    rst = 1'b0; start = 1'b0; din = '0; sel = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("reset_outs_a", {busy_a, done_a, ser_a, shcp_a, stcp_a}, 5'b0);
    chk("reset_outs_b", {busy_b, done_b, ser_b, shcp_b, stcp_b}, 5'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Table-driven single frames on the 8-bit / DIV=2 instance
    foreach (vecs[i]) begin
`ifdef W_HC595_LSB_FIRST_EN
      exp = vecs[i].exp_lsb;
`else
      exp = vecs[i].exp_msb;
`endif
      run_frame(vecs[i].din, vecs[i].din, 0, 0, 1);
      chk("frame_timeout", o_timeout, 0);
      chk("frame_ser_bits", o_cap, exp);
      chk("frame_rises", o_rises, 8);
      chk("frame_busy_cycles", o_busy, 35);
      chk("frame_shcp_high", o_shcp_hi, 16);
      chk("frame_stcp_width", o_stcp, 2);
      chk("frame_done_pulses", o_done, 1);
      chk("frame_ser_stable_at_rise", o_serchg, 0);
      chk("frame_idle_outs", o_idle, 4'b0);
      chk("frame_latched", latch_a, exp);
    end

    // Request during bit 4 must be ignored, neither captured nor queued
    run_frame(8'hA5, 8'hA5, 0, 4, 1);
    chk("busyreq_ser_bits", o_cap, 8'hA5);
    chk("busyreq_busy_cycles", o_busy, 35);
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (m_busy) extra++;
    end
    chk("busyreq_no_second_frame", extra, 0);

    // Back-to-back with START held: exactly one IDLE cycle between frames
    run_frame(8'hFF, 8'h00, 1, 0, 1);
    chk("b2b_first_bits", o_cap, 8'hFF);
    chk("b2b_first_busy", o_busy, 35);
    chk("b2b_first_done", o_done, 1);
    run_frame(8'h00, 8'h00, 0, 0, 0);
    chk("b2b_one_idle_gap", o_first_busy, 1);
    chk("b2b_second_bits", o_cap, 8'h00);
    chk("b2b_second_busy", o_busy, 35);
    chk("b2b_second_latched", latch_a, 8'h00);
    repeat (4) @(negedge clk);

    // Reset during bit 3, then reset-release start suppression
    @(negedge clk);
    din = 8'hA5; start = 1'b1;
    rs = 0; stc = 0; dn = 0; prev = 0;
    for (int k = 0; k < 100 && rs < 4; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (m_shcp && !prev) rs++;
      prev = m_shcp;
      stc += int'(m_stcp);
      dn  += int'(m_done);
    end
    chk("rstmid_reached_bit3", rs, 4);
    chk("rstmid_shcp_before", m_shcp, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("rstmid_outs_immediate", {busy_a, done_a, ser_a, shcp_a, stcp_a}, 5'b0);
    repeat (2) begin
      @(negedge clk);
      stc += int'(m_stcp);
      dn  += int'(m_done);
    end
    chk("rstmid_outs_held", {busy_a, done_a, ser_a, shcp_a, stcp_a}, 5'b0);
    chk("rstmid_no_stcp", stc, 0);
    chk("rstmid_no_done", dn, 0);
    rst = 1'b0; start = 1'b1; din = 8'hA5;
    @(negedge clk);
    chk("rst_release_first_edge_ignored", busy_a, 1'b0);
    run_frame(8'hA5, 8'hA5, 0, 0, 0);
    chk("rst_release_second_edge_accept", o_first_busy, 1);
    chk("rst_release_frame_bits", o_cap, 8'hA5);
    chk("rst_release_frame_busy", o_busy, 35);
    repeat (3) @(negedge clk);

    // WIDTH=4, DIV=1 instance
    sel = 1'b1;
    @(negedge clk);
    run_frame(8'h09, 8'h09, 0, 0, 1);
    chk("div1_timeout", o_timeout, 0);
    chk("div1_ser_bits", o_cap, 8'h09);
    chk("div1_rises", o_rises, 4);
    chk("div1_shcp_high", o_shcp_hi, 4);
    chk("div1_busy_cycles", o_busy, 10);
    chk("div1_stcp_width", o_stcp, 1);
    chk("div1_done_pulses", o_done, 1);
    chk("div1_latched", latch_b[3:0], 4'h9);
    sel = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
